// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain with per-stage valid bits.
// Valid/ready handshake per stage, per-stage flush, global stall.
module pipe_stage_chain #(
    parameter int WIDTH         = 64,
    parameter int STAGES        = 4,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_W         = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              stall,
    input  logic [STAGES-1:0] flush,
    output logic [CNT_W-1:0]  occupancy,
    output logic              busy
);

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_data [STAGES];

    logic [STAGES-1:0] w_ev;
    logic [STAGES:0]   w_acc;
    logic [STAGES-1:0] w_in_v;
    logic [WIDTH-1:0]  w_in_d [STAGES];

    assign w_ev = r_v & ~flush;

    // Accept chain: ready ripples back from the output to the input
    always_comb begin
        w_acc[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc[i] = ~stall & (~w_ev[i] | w_acc[i+1]);
        end
    end

    assign in_ready  = w_acc[0];
    assign out_valid = w_ev[STAGES-1] & ~stall;
    assign out_data  = r_data[STAGES-1];

    assign w_in_v[0] = in_valid;
    assign w_in_d[0] = in_data;

    genvar g;
    generate
        for (g = 1; g < STAGES; g++) begin : g_link
            assign w_in_v[g] = w_ev[g-1];
            assign w_in_d[g] = r_data[g-1];
        end

        for (g = 0; g < STAGES; g++) begin : g_stage
            logic w_load;
            assign w_load = w_acc[g] & w_in_v[g];

            // Stage register: take the upstream item, drop a flushed one,
            // otherwise hold
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v[g]    <= 1'b0;
                    r_data[g] <= '0;
                end else begin
                    r_v[g] <= w_acc[g] ? w_in_v[g] : w_ev[g];
                    if (w_load) begin
                        r_data[g] <= w_in_d[g];
                    end else if (flush[g] && ZERO_ON_FLUSH) begin
                        r_data[g] <= '0;
                    end
                end
            end
        end
    endgenerate

    // Occupancy counts registered valids, flushed-this-cycle included
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + CNT_W'(r_v[i]);
        end
    end

    assign busy = |r_v;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain.
// STAGES=4, WIDTH=8; inputs driven and outputs sampled 1ns after posedge.
module tb_pipe_stage_chain;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int CW = $clog2(S + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          stall;
    logic [S-1:0]  flush;
    logic [CW-1:0] occupancy;
    logic          busy;

    int n_chk;
    int n_err;

    pipe_stage_chain #(
        .WIDTH(W),
        .STAGES(S),
        .ZERO_ON_FLUSH(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .stall(stall),
        .flush(flush),
        .occupancy(occupancy),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // 1. reset with garbage on the input
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        out_ready = 1'b0; stall = 1'b0; flush = '0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 1);

        // 2. streaming
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; tick();
        chk("str_busy", 32'(busy), 1);
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        chk("str_occ3", 32'(occupancy), 3);
        chk("str_noout", 32'(out_valid), 0);
        in_valid = 1'b0; tick();
        chk("str_v4", 32'(out_valid), 1);
        chk("str_d4", 32'(out_data), 32'h11);
        tick();
        chk("str_d5", 32'(out_data), 32'h22);
        tick();
        chk("str_d6", 32'(out_data), 32'h33);
        chk("str_occ6", 32'(occupancy), 1);
        tick();
        chk("str_empty", 32'(out_valid), 0);
        chk("str_occ0", 32'(occupancy), 0);

        // 3. backpressure
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick();
        in_data = 8'hA4; tick();
        in_data = 8'hA5; settle();
        chk("bp_occ4", 32'(occupancy), 4);
        chk("bp_full", 32'(in_ready), 0);
        chk("bp_out", 32'(out_data), 32'hA1);
        chk("bp_outv", 32'(out_valid), 1);
        stall = 1'b1; settle();
        chk("bp_stall_ov", 32'(out_valid), 0);
        stall = 1'b0;
        out_ready = 1'b1; settle();
        chk("bp_ready_comb", 32'(in_ready), 1);
        tick();
        chk("bp_occ_keep", 32'(occupancy), 4);
        chk("bp_next", 32'(out_data), 32'hA2);
        in_valid = 1'b0; tick();
        chk("bp_d3", 32'(out_data), 32'hA3);
        tick();
        chk("bp_d4", 32'(out_data), 32'hA4);
        tick();
        chk("bp_d5", 32'(out_data), 32'hA5);
        tick();
        chk("bp_drained", 32'(occupancy), 0);

        // 4. bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("bc_occ1", 32'(occupancy), 1);
        chk("bc_head", 32'(out_data), 32'h01);
        in_valid = 1'b1; in_data = 8'h02; tick();
        in_valid = 1'b0; tick(); tick();
        chk("bc_occ2", 32'(occupancy), 2);
        chk("bc_head2", 32'(out_data), 32'h01);
        out_ready = 1'b1; tick();
        chk("bc_b2b_v", 32'(out_valid), 1);
        chk("bc_b2b_d", 32'(out_data), 32'h02);
        tick();
        chk("bc_empty", 32'(occupancy), 0);

        // 5. flush middle stage with concurrent upstream transfer
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hD4; tick();
        in_data = 8'hD3; tick();
        in_data = 8'hD2; tick();
        in_data = 8'hD1; tick();
        flush = 4'b0100; in_data = 8'hD5; settle();
        chk("fl_in_ready", 32'(in_ready), 1);
        chk("fl_occ_counts", 32'(occupancy), 4);
        tick();
        flush = '0; in_valid = 1'b0; settle();
        chk("fl_occ_after", 32'(occupancy), 4);
        out_ready = 1'b1; settle();
        chk("fl_d0", 32'(out_data), 32'hD4);
        tick();
        chk("fl_d1", 32'(out_data), 32'hD2);
        tick();
        chk("fl_d2", 32'(out_data), 32'hD1);
        tick();
        chk("fl_d3", 32'(out_data), 32'hD5);
        tick();
        chk("fl_empty", 32'(out_valid), 0);

        // 6. stall with flush, then reset under stall
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hE1; tick();
        in_data = 8'hE2; tick();
        in_data = 8'hE3; stall = 1'b1; settle();
        chk("st_in_ready", 32'(in_ready), 0);
        chk("st_out_valid", 32'(out_valid), 0);
        tick();
        chk("st_occ2", 32'(occupancy), 2);
        flush = 4'b0001; tick();
        flush = '0;
        chk("st_occ1", 32'(occupancy), 1);
        tick();
        chk("st_occ1b", 32'(occupancy), 1);
        rst = 1'b1; tick();
        chk("st_rst_occ", 32'(occupancy), 0);
        chk("st_rst_busy", 32'(busy), 0);

        // 7. flush of the output stage: killed combinationally, zeroed
        rst = 1'b0; stall = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77; tick();
        in_valid = 1'b0; tick(); tick(); tick();
        chk("zf_head", 32'(out_data), 32'h77);
        flush = 4'b1000; settle();
        chk("zf_kill_comb", 32'(out_valid), 0);
        tick();
        flush = '0;
        chk("zf_zero", 32'(out_data), 32'h00);
        chk("zf_occ", 32'(occupancy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline-register chain. Replaces the hand-instantiated, globally-enabled IF/ID, ID/EX, EX/MEM and MEM/WB register pairs with one reusable block.
- Each stage carries a valid bit and moves on a valid/ready handshake, so bubbles collapse.
- Adds what the current core lacks: per-stage flush for branch redirect, global stall for load-use hazards, and an occupancy count for hazard/debug logic.

Parameters:
WIDTH, 64, bits of payload per stage (data and control packed together)
STAGES, 4, number of register stages (>=1)
ZERO_ON_FLUSH, 1, 1 = a flushed stage's payload register is cleared to 0; 0 = payload is held
CNT_W, $clog2(STAGES+1), width of occupancy

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream presents in_data
in_ready  output  1  chain accepts in_data this cycle
in_data  input  WIDTH  payload into stage 0
out_valid  output  1  stage STAGES-1 presents out_data
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  payload of stage STAGES-1
stall  input  1  global hold: no transfers anywhere
flush  input  STAGES  bit i kills the item held in stage i at the next edge
occupancy  output  CNT_W  number of valid stages (popcount of v)
busy  output  1  occupancy != 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Every register changes only on the rising edge.
- Reset:
  - all v[i]=0; all payload registers=0.
  - Outputs after the reset edge: out_valid=0, out_data=0, occupancy=0, busy=0.
  - in_ready=1 unless stall=1.
  - rst has priority over stall, flush and any handshake, including mid-stream; all in-flight items are lost.
- Effective valid: ev[i] = v[i] & ~flush[i]. A flushed item never moves forward and never appears at the output, even combinationally.
- Accept chain, computed combinationally from the last stage back:
  - acc[STAGES] = out_ready.
  - acc[i] = ~stall & (~ev[i] | acc[i+1]).
  - in_ready = acc[0]; out_valid = ev[STAGES-1] & ~stall; out_data = payload[STAGES-1].
  - Ready passes combinationally from out_ready to in_ready. The zero-bubble full-throughput path is intended.
- Next state of stage i:
  - If acc[i]=1: v[i] <= incoming valid, which is in_valid for i=0 and ev[i-1] otherwise. The payload loads the incoming payload only when the incoming valid is 1; otherwise the payload holds.
  - If acc[i]=0: v[i] <= ev[i].
  - If flush[i]=1 and ZERO_ON_FLUSH=1 and no new item loads, the payload is cleared to 0.
- Flush with a simultaneous upstream transfer: stage i may accept from stage i-1 in the same cycle it is flushed. The flushed item is discarded and the new item is kept.
- Stall:
  - freezes every valid item and payload.
  - forces in_ready=0 and out_valid=0.
  - flush still applies during stall (flush has priority over stall).
- Latency: with no backpressure, an item accepted at edge n is presented on out_data after edge n+STAGES-1. Throughput is one item per cycle.
- Full condition: all v=1 and out_ready=0 gives in_ready=0. Empty condition: occupancy=0 gives out_valid=0.
- occupancy is registered-derived (popcount of v), not of ev. It therefore still counts a stage during the cycle its flush is asserted.

Test Plan:
1. Reset, STAGES=4, WIDTH=8: hold rst=1 for 2 edges with in_valid=1 and in_data=0xFF -> out_valid=0, occupancy=0, busy=0, out_data=0x00, in_ready=1.
2. Streaming: out_ready=1; drive 0x11, 0x22, 0x33 on consecutive edges 1-3 -> out_valid=1 with out_data 0x11, 0x22, 0x33 after edges 4, 5, 6; occupancy peaks at 3.
3. Backpressure: out_ready=0, drive 0xA1 through 0xA4 -> after 4 accepts, occupancy=4 and in_ready=0. Raise out_ready with in_valid=1 and in_data=0xA5 -> in_ready=1 in the same cycle; 0xA1 retires; occupancy stays 4.
4. Bubble collapse: out_ready=0, send 0x01, wait 5 cycles, send 0x02 -> 0x01 sits in stage 3, 0x02 advances to stage 2 after 3 more edges, occupancy=2; the pair then drains back-to-back.
5. Flush: stages 3..0 hold 0xD4, 0xD3, 0xD2, 0xD1 with out_ready=0; pulse flush=4'b0100 while in_valid=1 and in_data=0xD5 -> only 0xD3 is removed, 0xD1 and 0xD2 advance into the hole, 0xD5 enters stage 0; drain order is 0xD4, 0xD2, 0xD1, 0xD5.
6. Stall and reset mid-stream: fill 2 items, assert stall for 3 cycles with flush=4'b0001 in one of those cycles -> out_valid=0, in_ready=0, the stage-0 item is removed, occupancy drops to 1. Then assert rst with stall=1 -> occupancy=0 after one edge.
